tlb_arbiter: RTL and testbench

- Shares the single TLB translation port between the instruction-fetch requester (port F) and the load/store requester (port D).
- Grants one requester at a time using round-robin arbitration.
- Latches the granted request and holds it stable on the TLB until it completes or errors.
- Returns the TLB response, data and error flags to the granted requester as a one-cycle done pulse.

---
 rtl/tlb_arb_pkg.sv | 33 +++
 rtl/tlb_arbiter_rr.sv | 23 ++
 rtl/tlb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_tlb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_arb_pkg.sv
// Shared types and error-bit layout for the TLB port arbiter.
// Error vector widths grow by one timeout bit when TLB_ARB_TIMEOUT_EN is defined.
package tlb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_F,
        GRANT_D,
        RESP
    } state_t;

    typedef enum logic {
        REQ_F,
        REQ_D
    } req_id_t;

    localparam int F_ERR_NOT_PRESENT = 0;
    localparam int F_ERR_NOT_USER    = 1;
    localparam int D_ERR_NOT_PRESENT = 0;
    localparam int D_ERR_NOT_USER    = 1;
    localparam int D_ERR_BAD_REQ     = 2;

`ifdef TLB_ARB_TIMEOUT_EN
    localparam int F_ERR_TIMEOUT = 2;
    localparam int D_ERR_TIMEOUT = 3;
    localparam int F_ERR_W       = 3;
    localparam int D_ERR_W       = 4;
`else
    localparam int F_ERR_W       = 2;
    localparam int D_ERR_W       = 3;
`endif

endpackage

// File: rtl/tlb_arbiter_rr.sv
// Two-way round-robin pick: with both requesters eligible, the one that did
// not win last time is chosen. Purely combinational; last_grant lives in the parent.
module rr_arbiter2
    import tlb_arb_pkg::*;
(
    input  logic    elig_f,
    input  logic    elig_d,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant
);

    always_comb begin
        grant_valid = elig_f | elig_d;
        grant       = REQ_F;
        if (elig_f && elig_d) begin
            grant = (last_grant == REQ_F) ? REQ_D : REQ_F;
        end else if (elig_d) begin
            grant = REQ_D;
        end
    end

endmodule

// File: rtl/tlb_arbiter.sv
// Shares one TLB port between fetch (F) and load/store (D) requesters.
// Optional watchdog enabled by defining TLB_ARB_TIMEOUT_EN.
module tlb_arbiter
    import tlb_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               f_read,
    input  logic [ADDR_W-1:0]  f_address,
    input  logic               f_is_user,
    output logic               f_done,
    output logic [DATA_W-1:0]  f_rdata,
    output logic [F_ERR_W-1:0] f_err,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [DATA_W-1:0]  d_wdata,
    input  logic               d_is_user,
    output logic               d_done,
    output logic [DATA_W-1:0]  d_rdata,
    output logic [D_ERR_W-1:0] d_err,
    output logic [ADDR_W-1:0]  tlb_address,
    output logic               tlb_read,
    output logic               tlb_write,
    output logic [DATA_W-1:0]  tlb_wdata,
    output logic               tlb_is_user,
    input  logic               tlb_valid,
    input  logic [DATA_W-1:0]  tlb_rdata,
    input  logic               tlb_err_not_present,
    input  logic               tlb_err_not_user
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_q, state_d;
    req_id_t            last_grant_q, resp_id_q, pick;
    logic               pick_valid, elig_f, elig_d, bad_req;
    logic               f_block_q, d_block_q;
    logic               in_grant, tlb_response, tlb_finish, timeout_hit;
    logic [ADDR_W-1:0]  lat_address;
    logic [DATA_W-1:0]  lat_wdata, f_rdata_q, d_rdata_q;
    logic               lat_is_user, lat_read, lat_write;
    logic [F_ERR_W-1:0] f_err_q, f_err_new;
    logic [D_ERR_W-1:0] d_err_q, d_err_new;

    // A port whose done pulsed last cycle sits out one IDLE cycle so a held request is not re-granted.
    assign elig_f       = f_read && !f_done && !f_block_q;
    assign elig_d       = (d_read || d_write) && !d_done && !d_block_q;
    assign bad_req      = d_read && d_write;
    assign in_grant     = (state_q == GRANT_F) || (state_q == GRANT_D);
    assign tlb_response = tlb_valid | tlb_err_not_present | tlb_err_not_user;
    assign tlb_finish   = tlb_response | timeout_hit;

    rr_arbiter2 u_rr (
        .elig_f      (elig_f),
        .elig_d      (elig_d),
        .last_grant  (last_grant_q),
        .grant_valid (pick_valid),
        .grant       (pick)
    );

`ifdef TLB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wd_count;

    always_ff @(posedge clock) begin
        if (!reset || !in_grant) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 1'b1;
        end
    end

    assign timeout_hit = in_grant && !tlb_response && (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        f_err_new = '0;
        d_err_new = '0;
        f_err_new[F_ERR_NOT_PRESENT] = tlb_err_not_present;
        f_err_new[F_ERR_NOT_USER]    = tlb_err_not_user;
        d_err_new[D_ERR_NOT_PRESENT] = tlb_err_not_present;
        d_err_new[D_ERR_NOT_USER]    = tlb_err_not_user;
`ifdef TLB_ARB_TIMEOUT_EN
        f_err_new[F_ERR_TIMEOUT]     = timeout_hit;
        d_err_new[D_ERR_TIMEOUT]     = timeout_hit;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (pick == REQ_F) begin
                        state_d = GRANT_F;
                    end else begin
                        state_d = bad_req ? RESP : GRANT_D;
                    end
                end
            end
            GRANT_F, GRANT_D: begin
                if (tlb_finish) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tlb_read    = in_grant && lat_read;
        tlb_write   = in_grant && lat_write;
        tlb_address = lat_address;
        tlb_wdata   = lat_wdata;
        tlb_is_user = lat_is_user;
        f_done      = (state_q == RESP) && (resp_id_q == REQ_F);
        d_done      = (state_q == RESP) && (resp_id_q == REQ_D);
        f_rdata     = f_rdata_q;
        f_err       = f_err_q;
        d_rdata     = d_rdata_q;
        d_err       = d_err_q;
    end

    // Request latch and response capture; the TLB sees only latched values during a grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= REQ_D;
            resp_id_q    <= REQ_F;
            f_block_q    <= 1'b0;
            d_block_q    <= 1'b0;
            lat_address  <= '0;
            lat_wdata    <= '0;
            lat_is_user  <= 1'b0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            f_rdata_q    <= '0;
            f_err_q      <= '0;
            d_rdata_q    <= '0;
            d_err_q      <= '0;
        end else begin
            f_block_q <= f_done;
            d_block_q <= d_done;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        resp_id_q <= pick;
                        if (pick == REQ_F) begin
                            lat_address <= f_address;
                            lat_wdata   <= '0;
                            lat_is_user <= f_is_user;
                            lat_read    <= 1'b1;
                            lat_write   <= 1'b0;
                        end else if (bad_req) begin
                            last_grant_q <= REQ_D;
                            d_rdata_q    <= '0;
                            d_err_q      <= D_ERR_W'(1) << D_ERR_BAD_REQ;
                        end else begin
                            lat_address <= d_address;
                            lat_wdata   <= d_wdata;
                            lat_is_user <= d_is_user;
                            lat_read    <= d_read;
                            lat_write   <= d_write;
                        end
                    end
                end
                GRANT_F: begin
                    if (tlb_finish) begin
                        f_rdata_q    <= tlb_rdata;
                        f_err_q      <= f_err_new;
                        last_grant_q <= REQ_F;
                    end
                end
                GRANT_D: begin
                    if (tlb_finish) begin
                        d_rdata_q    <= tlb_rdata;
                        d_err_q      <= d_err_new;
                        last_grant_q <= REQ_D;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_arbiter.sv
// Directed bench for tlb_arbiter: a cycle table plus hand sequences for
// round-robin, reset mid-grant and (with TLB_ARB_TIMEOUT_EN) the watchdog.
module tb_tlb_arbiter;
    import tlb_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic               f_read, f_is_user, f_done;
    logic [ADDR_W-1:0]  f_address;
    logic [DATA_W-1:0]  f_rdata;
    logic [F_ERR_W-1:0] f_err;
    logic               d_read, d_write, d_is_user, d_done;
    logic [ADDR_W-1:0]  d_address;
    logic [DATA_W-1:0]  d_wdata, d_rdata;
    logic [D_ERR_W-1:0] d_err;
    logic [ADDR_W-1:0]  tlb_address;
    logic               tlb_read, tlb_write, tlb_is_user, tlb_valid;
    logic [DATA_W-1:0]  tlb_wdata, tlb_rdata;
    logic               tlb_err_not_present, tlb_err_not_user;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tlb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .f_read(f_read), .f_address(f_address), .f_is_user(f_is_user),
        .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_is_user(d_is_user), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .tlb_address(tlb_address), .tlb_read(tlb_read), .tlb_write(tlb_write),
        .tlb_wdata(tlb_wdata), .tlb_is_user(tlb_is_user), .tlb_valid(tlb_valid),
        .tlb_rdata(tlb_rdata), .tlb_err_not_present(tlb_err_not_present),
        .tlb_err_not_user(tlb_err_not_user)
    );

    typedef struct {
        logic rst, fr, fu, dr, dw, du, tv, tnu;
        logic [31:0] fa, da, dwd, trd;
        logic e_rd, e_wr, e_user, e_fd, e_dd;
        logic [31:0] e_addr, e_wdata, e_frd, e_drd;
        logic [F_ERR_W-1:0] e_ferr;
        logic [D_ERR_W-1:0] e_derr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, fr, fu, dr, dw, du, tv, tnu,
                                input logic [31:0] fa, da, dwd, trd,
                                input logic rd, wr, user, fd, dd,
                                input logic [31:0] addr, wdata, frd, drd,
                                input logic [1:0] ferr, input logic [2:0] derr);
        vec_t v;
        v.rst = rst; v.fr = fr; v.fu = fu; v.dr = dr; v.dw = dw; v.du = du; v.tv = tv; v.tnu = tnu;
        v.fa = fa; v.da = da; v.dwd = dwd; v.trd = trd;
        v.e_rd = rd; v.e_wr = wr; v.e_user = user; v.e_fd = fd; v.e_dd = dd;
        v.e_addr = addr; v.e_wdata = wdata; v.e_frd = frd; v.e_drd = drd;
        v.e_ferr = F_ERR_W'(ferr);
        v.e_derr = D_ERR_W'(derr);
        return v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        reset = 1'b1; f_read = 1'b0; f_address = '0; f_is_user = 1'b0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_is_user = 1'b0;
        tlb_valid = 1'b0; tlb_rdata = '0; tlb_err_not_present = 1'b0; tlb_err_not_user = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst; f_read = v.fr; f_address = v.fa; f_is_user = v.fu;
        d_read = v.dr; d_write = v.dw; d_address = v.da; d_wdata = v.dwd; d_is_user = v.du;
        tlb_valid = v.tv; tlb_rdata = v.trd; tlb_err_not_user = v.tnu; tlb_err_not_present = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        logic [31:0] exp_addr;
        idle_inputs();
        reset = 1'b0;

        vecs[0]  = mk(0,1,1,0,0,0,0,0, 'h4000,0,0,0,            0,0,0,0,0, 0,0,0,0,0,0);
        vecs[1]  = mk(0,1,1,0,0,0,0,0, 'h4000,0,0,0,            0,0,0,0,0, 0,0,0,0,0,0);
        vecs[2]  = mk(1,1,1,0,0,0,0,0, 'h4000,0,0,0,            1,0,1,0,0, 'h4000,0,0,0,0,0);
        vecs[3]  = mk(1,1,1,0,0,0,1,0, 'h4000,0,0,'hCAFE,       0,0,1,1,0, 'h4000,0,'hCAFE,0,0,0);
        vecs[4]  = mk(1,0,1,0,0,0,0,0, 'h4000,0,0,0,            0,0,1,0,0, 'h4000,0,'hCAFE,0,0,0);
        vecs[5]  = mk(1,0,1,0,1,0,0,0, 'h4000,'hABCD,'h1234,0,  0,1,0,0,0, 'hABCD,'h1234,'hCAFE,0,0,0);
        vecs[6]  = mk(1,0,1,0,1,0,0,0, 'h4000,'hABCD,'h1234,0,  0,1,0,0,0, 'hABCD,'h1234,'hCAFE,0,0,0);
        vecs[7]  = mk(1,0,1,0,1,0,0,0, 'h4000,'h1111,'h1234,0,  0,1,0,0,0, 'hABCD,'h1234,'hCAFE,0,0,0);
        vecs[8]  = mk(1,0,1,0,1,0,1,0, 'h4000,'h1111,'h1234,'h55, 0,0,0,0,1, 'hABCD,'h1234,'hCAFE,'h55,0,0);
        vecs[9]  = mk(1,0,1,0,0,0,0,0, 'h4000,0,0,0,            0,0,0,0,0, 'hABCD,'h1234,'hCAFE,'h55,0,0);
        vecs[10] = mk(1,0,1,0,0,0,0,0, 'h4000,0,0,0,            0,0,0,0,0, 'hABCD,'h1234,'hCAFE,'h55,0,0);
        vecs[11] = mk(1,0,1,1,0,1,0,0, 'h4000,'h8000,0,0,       1,0,1,0,0, 'h8000,0,'hCAFE,'h55,0,0);
        vecs[12] = mk(1,0,1,1,0,1,0,1, 'h4000,'h8000,0,'h77,    0,0,1,0,1, 'h8000,0,'hCAFE,'h77,0,3'b010);
        vecs[13] = mk(1,0,1,0,0,1,0,0, 'h4000,0,0,0,            0,0,1,0,0, 'h8000,0,'hCAFE,'h77,0,3'b010);
        vecs[14] = mk(1,0,1,0,0,1,0,0, 'h4000,0,0,0,            0,0,1,0,0, 'h8000,0,'hCAFE,'h77,0,3'b010);
        vecs[15] = mk(1,0,1,1,1,1,0,0, 'h4000,'h9000,0,0,       0,0,1,0,1, 'h8000,0,'hCAFE,0,0,3'b100);
        vecs[16] = mk(1,0,1,0,0,1,0,0, 'h4000,0,0,0,            0,0,1,0,0, 'h8000,0,'hCAFE,0,0,3'b100);

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output($sformatf("vec%0d", i),
                {tlb_read, tlb_write, tlb_is_user, f_done, d_done, tlb_address, tlb_wdata,
                 f_rdata, d_rdata, f_err, d_err},
                {vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_user, vecs[i].e_fd, vecs[i].e_dd,
                 vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_frd, vecs[i].e_drd,
                 vecs[i].e_ferr, vecs[i].e_derr});
        end

        // Both requesters held continuously: grants must alternate starting with F.
        idle_inputs();
        tick(); tick();
        f_read = 1'b1; f_address = 'h100; d_read = 1'b1; d_address = 'h200;
        for (int t = 0; t < 5; t++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (tlb_read) got = 1'b1;
            end
            exp_addr = (t % 2 == 0) ? 32'h100 : 32'h200;
            check_output($sformatf("rr%0d_grant", t), {got, tlb_address}, {1'b1, exp_addr});
            tlb_valid = 1'b1; tlb_rdata = 32'(t);
            tick();
            tlb_valid = 1'b0;
            check_output($sformatf("rr%0d_done", t), {f_done, d_done}, (t % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check_output($sformatf("rr%0d_pulse", t), {f_done, d_done}, 2'b00);
        end

        // After F won last, a fresh tie must go to D.
        f_read = 1'b0; d_read = 1'b0;
        tick(); tick();
        f_read = 1'b1; d_read = 1'b1;
        tick();
        check_output("tie_to_d", {tlb_read, tlb_address}, {1'b1, 32'h200});
        tlb_valid = 1'b1; tlb_rdata = 'h99;
        tick();
        tlb_valid = 1'b0; f_read = 1'b0; d_read = 1'b0;
        check_output("tie_done", {f_done, d_done, d_rdata}, {2'b01, 32'h99});
        tick(); tick();

        // Reset in the middle of a grant abandons the transaction.
        d_read = 1'b1; d_address = 'h300;
        tick();
        check_output("rst_pre", {tlb_read, tlb_address}, {1'b1, 32'h300});
        reset = 1'b0;
        tick();
        check_output("rst_drop", {tlb_read, tlb_write, f_done, d_done, d_rdata, d_err}, '0);
        reset = 1'b1; d_read = 1'b0;
        tick();
        check_output("rst_quiet", {tlb_read, tlb_write, f_done, d_done}, 4'b0000);
        f_read = 1'b1; f_address = 'h400; d_read = 1'b1; d_address = 'h300;
        tick();
        check_output("rst_regrant", {tlb_read, tlb_address}, {1'b1, 32'h400});
        tlb_valid = 1'b1;
        tick();
        tlb_valid = 1'b0; f_read = 1'b0; d_read = 1'b0;
        tick(); tick();

`ifdef TLB_ARB_TIMEOUT_EN
        begin
            int n_strobe;
            bit done_seen;
            n_strobe  = 0;
            done_seen = 1'b0;
            f_read = 1'b1; f_address = 'h500;
            tick();
            f_read = 1'b0;
            for (int c = 0; c < 20 && !done_seen; c++) begin
                if (tlb_read) n_strobe++;
                if (f_done) done_seen = 1'b1;
                else tick();
            end
            check_output("to_cycles", 160'(n_strobe), 160'd8);
            check_output("to_err", {done_seen, tlb_read, f_err}, {1'b1, 1'b0, 3'b100});
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
